// File: rtl/m68k_bus_capture.sv
// m68k_bus_capture: captures completed 68000 bus cycles into a FIFO and shows
// one entry at a time to the bus-monitor overlay. A new entry is shown only in
// the cycle after a frame_start pulse, after the current one has been held for
// HOLD_FRAMES frames.
// Optional feature macro: BUS_CAPTURE_OVERFLOW_CNT_EN adds a saturating
// dropped-capture counter on port overflow_count.
module m68k_bus_capture #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_valid,
    input  logic [31:0]              cap_addr,
    input  logic [15:0]              cap_data,
    input  logic                     cap_write,
    input  logic                     frame_start,
    input  logic                     freeze,
    output logic [31:0]              m68k_addr,
    output logic [15:0]              m68k_datain,
    output logic                     m68k_write,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
    ,
    output logic [15:0]              overflow_count
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);

    typedef struct packed {
        logic        write;
        logic [15:0] data;
        logic [31:0] addr;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              cap_entry;
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [LVL_W-1:0]    level_d;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [HOLD_W-1:0]   hold_cnt_d;
    logic                pop_c;
    logic                push_c;

    assign cap_entry  = '{write: cap_write, data: cap_data, addr: cap_addr};
    assign head       = mem_q[rd_ptr_q];
    assign fifo_level = level_q;

    // Pop/push decisions, occupancy and hold-counter next state
    always_comb begin
        pop_c      = 1'b0;
        push_c     = 1'b0;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;

        pop_c  = frame_start && (hold_cnt_q == HOLD_MAX) && (level_q != '0) && !freeze;
        push_c = cap_valid && ((level_q != LVL_FULL) || pop_c);

        if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            level_d = level_q - LVL_W'(1);
        end

        if (pop_c) begin
            hold_cnt_d = '0;
        end else if (frame_start && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cap_entry;
        end
    end

    // Pointers, occupancy and hold counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hold_cnt_q <= HOLD_MAX;
        end else begin
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Displayed entry: loads the FIFO head only on a qualifying frame_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m68k_addr   <= '0;
            m68k_datain <= '0;
            m68k_write  <= 1'b0;
        end else if (pop_c) begin
            m68k_addr   <= head.addr;
            m68k_datain <= head.data;
            m68k_write  <= head.write;
        end
    end

`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
    logic        drop_c;
    logic [15:0] overflow_q;

    assign drop_c         = cap_valid && !push_c;
    assign overflow_count = overflow_q;

    // Saturating count of captures dropped on a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= '0;
        end else if (drop_c && (overflow_q != 16'hFFFF)) begin
            overflow_q <= overflow_q + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_m68k_bus_capture.sv
// Self-checking bench for m68k_bus_capture (DEPTH=4, HOLD_FRAMES=3).
// Stimulus is applied on the falling edge; a queue-based reference model
// predicts the post-edge state and a monitor compares it after each rising edge.
module tb_m68k_bus_capture;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 3;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cap_valid;
    logic [31:0]       cap_addr;
    logic [15:0]       cap_data;
    logic              cap_write;
    logic              frame_start;
    logic              freeze;
    logic [31:0]       m68k_addr;
    logic [15:0]       m68k_datain;
    logic              m68k_write;
    logic [LVL_W-1:0]  fifo_level;
`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
    logic [15:0]       overflow_count;
`endif

    m68k_bus_capture #(.DEPTH(DEPTH), .HOLD_FRAMES(HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .cap_valid   (cap_valid),
        .cap_addr    (cap_addr),
        .cap_data    (cap_data),
        .cap_write   (cap_write),
        .frame_start (frame_start),
        .freeze      (freeze),
        .m68k_addr   (m68k_addr),
        .m68k_datain (m68k_datain),
        .m68k_write  (m68k_write),
        .fifo_level  (fifo_level)
`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
        ,
        .overflow_count (overflow_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
        logic        w;
    } ent_t;

    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
        logic        w;
        int          lvl;
        int          ovf;
    } exp_t;

    // Reference model state
    ent_t model_q[$];
    ent_t disp;
    int   hold_frames_seen;
    int   ovf_model;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        disp             = '{a: 32'h0, d: 16'h0, w: 1'b0};
        hold_frames_seen = HOLD;
        ovf_model        = 0;
    endtask

    // One clock of stimulus; the model is advanced with the same inputs
    task automatic step(input bit cv, input logic [31:0] a, input logic [15:0] d,
                        input bit w, input bit fs, input bit frz);
        bit   do_pop;
        int   size_before;
        exp_t e;
        @(negedge clk);
        cap_valid   = cv;
        cap_addr    = a;
        cap_data    = d;
        cap_write   = w;
        frame_start = fs;
        freeze      = frz;

        size_before = model_q.size();
        // hold_frames_seen counts frames since the last display change, capped at HOLD
        do_pop = fs && (hold_frames_seen >= HOLD) && (size_before > 0) && !frz;
        if (fs && !do_pop && hold_frames_seen < HOLD) hold_frames_seen++;
        if (do_pop) begin
            disp = model_q.pop_front();
            hold_frames_seen = 1;
        end
        if (cv) begin
            if (size_before < DEPTH || do_pop)
                model_q.push_back('{a: a, d: d, w: w});
            else if (ovf_model < 65535)
                ovf_model++;
        end
        e = '{a: disp.a, d: disp.d, w: disp.w, lvl: model_q.size(), ovf: ovf_model};
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 16'h0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] a, input logic [15:0] d, input bit w);
        step(1, a, d, w, 0, 0);
    endtask

    // Wait until the monitor has consumed everything issued so far
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset applied away from any clock edge, checked immediately
    task automatic async_reset();
        @(posedge clk);
        #3;
        cap_valid   = 0;
        frame_start = 0;
        freeze      = 0;
        reset       = 1;
        #1;
        check("rst_addr",  m68k_addr,   0);
        check("rst_data",  m68k_datain, 0);
        check("rst_write", m68k_write,  0);
        check("rst_level", fifo_level,  0);
`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
        check("rst_ovf",   overflow_count, 0);
`endif
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    // Monitor: compares the DUT against each predicted post-edge state
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_addr",  m68k_addr,   e.a);
                check("sb_data",  m68k_datain, e.d);
                check("sb_write", m68k_write,  e.w);
                check("sb_level", fifo_level,  e.lvl);
`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
                check("sb_ovf",   overflow_count, e.ovf);
`endif
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1;
        cap_valid   = 0;
        cap_addr    = 0;
        cap_data    = 0;
        cap_write   = 0;
        frame_start = 0;
        freeze      = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        check("init_addr",  m68k_addr,  0);
        check("init_level", fifo_level, 0);

        // Single capture shown at the first frame_start after it is stored
        push(32'h00FF_0004, 16'h4E71, 0);
        idle(2);
        step(0, 32'h0, 16'h0, 0, 1, 0);
        settle();
        check("t1_addr",  m68k_addr,   32'h00FF_0004);
        check("t1_data",  m68k_datain, 16'h4E71);
        check("t1_write", m68k_write,  0);
        check("t1_level", fifo_level,  0);

        // Hold for three frames between entries
        async_reset();
        push(32'h0000_00AA, 16'h1111, 1);
        push(32'h0000_00BB, 16'h2222, 0);
        for (int p = 1; p <= 4; p++) begin
            step(0, 32'h0, 16'h0, 0, 1, 0);
            settle();
            check("t2_addr", m68k_addr, (p < 4) ? 32'h0000_00AA : 32'h0000_00BB);
            idle(1);
        end

        // Overflow on a 4-deep FIFO, oldest entries kept
        async_reset();
        for (int i = 1; i <= 6; i++) push(32'h1000_0000 + 32'(i), 16'(i), 0);
        settle();
        check("t3_level", fifo_level, 4);
`ifdef BUS_CAPTURE_OVERFLOW_CNT_EN
        check("t3_ovf", overflow_count, 2);
`endif
        // Full FIFO: pop and capture in the same cycle
        step(1, 32'h2000_0007, 16'h0007, 1, 1, 0);
        settle();
        check("t4_addr",  m68k_addr,  32'h1000_0001);
        check("t4_level", fifo_level, 4);
        for (int i = 0; i < 12; i++) step(0, 32'h0, 16'h0, 0, 1, 0);
        settle();
        check("t4_last", m68k_addr, 32'h2000_0007);

        // Freeze blocks pops but not the hold counter
        async_reset();
        push(32'h3000_0001, 16'hAAAA, 0);
        push(32'h3000_0002, 16'hBBBB, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 16'h0, 0, 1, 1);
            idle(1);
        end
        settle();
        check("t5_frozen", m68k_addr, 0);
        step(0, 32'h0, 16'h0, 0, 1, 0);
        settle();
        check("t5_thaw", m68k_addr, 32'h3000_0001);

        // Reset mid-operation with entries queued
        async_reset();
        push(32'h4000_0001, 16'h0001, 0);
        push(32'h4000_0002, 16'h0002, 0);
        push(32'h4000_0003, 16'h0003, 1);
        step(0, 32'h0, 16'h0, 0, 1, 0);
        idle(2);
        async_reset();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, $urandom, 16'($urandom), 1'($urandom),
                 ($urandom % 4) == 0, ($urandom % 8) == 0);
            if (i == 1500) async_reset();
        end
        settle();
        settle();
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_capture.md
# m68k_bus_capture

Captures completed 68000 bus cycles (address, data, direction) into a small FIFO and presents them one at a time to the on-screen bus monitor. Each displayed entry is held stable for a programmable number of video frames. Outputs change only in the cycle after a frame-start pulse, so the text overlay never tears mid-frame. Sits between the CPU bus tap and the display/textbox stage, driving its `m68k_addr`, `m68k_datain` and `m68k_write` inputs.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `HOLD_FRAMES`, 30: frames each entry stays on screen; ≥ 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cap_valid`  in  1  one-cycle pulse; a bus cycle completed this cycle.
- `cap_addr`  in  32  address of the completed cycle.
- `cap_data`  in  16  data of the completed cycle.
- `cap_write`  in  1  1 = write cycle, 0 = read cycle.
- `frame_start`  in  1  one-cycle pulse from the video timing generator at the start of each frame (x=0, y=0).
- `freeze`  in  1  when high, no new entry is popped to the display; capture continues.
- `m68k_addr`  out  32  displayed address, registered.
- `m68k_datain`  out  16  displayed data, registered.
- `m68k_write`  out  1  displayed direction, registered.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `overflow_count`  out  16  dropped-capture counter; present only with `BUS_CAPTURE_OVERFLOW_CNT_EN`.

## Operation
- Each FIFO entry is 49 bits: {write, data, addr}. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in a separate counter.
- Push: `cap_valid` and (not full, or a pop in the same cycle) → entry written; level +1 (net 0 when a pop coincides).
- Full and no same-cycle pop → the new capture is dropped and the FIFO is unchanged. The oldest entries are kept.
- Hold counter `hold_cnt` (0..HOLD_FRAMES-1) increments on `frame_start` and saturates at HOLD_FRAMES-1.
- Pop condition: `frame_start` and `hold_cnt == HOLD_FRAMES-1` and level > 0 and not `freeze`. On pop, the output registers load the head entry and `hold_cnt` is cleared to 0.
- Pop condition false: outputs hold their value.
- Pop is evaluated on the pre-cycle level. A push into an empty FIFO on the same cycle as `frame_start` is not bypassed; that entry is shown at the next qualifying `frame_start`.
- `freeze` only blocks pops. `hold_cnt` keeps counting and saturating, so the first `frame_start` after `freeze` falls pops immediately if data is waiting.
- HOLD_FRAMES = 1: every `frame_start` with data pops.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` deassert at the source):
  - `m68k_addr` = 0, `m68k_datain` = 0, `m68k_write` = 0.
  - `fifo_level` = 0, pointers = 0, `overflow_count` = 0.
  - `hold_cnt` = HOLD_FRAMES-1, so the first capture is shown at the first `frame_start` after it is stored.
- Reset mid-operation discards all FIFO contents and the displayed entry.
- `cap_valid` at cycle n → `fifo_level` updated at n+1.
- Pop at cycle n (`frame_start` high) → outputs and `fifo_level` updated at n+1.
- Minimum capture-to-display latency: 2 cycles (push at n, `frame_start` at n+1, outputs at n+2).
- Outputs change only at n+1 after a `frame_start` at n; they are never updated at any other time.
- No ready/backpressure toward the capture side: `cap_valid` is never stalled, only dropped when the FIFO is full.

## Configuration
- `BUS_CAPTURE_OVERFLOW_CNT_EN` defined:
  - `overflow_count` port exists.
  - Increments by 1 on each dropped capture and saturates at 16'hFFFF.
  - Cleared only by reset.
- Not defined: port and counter absent. Dropped captures are silently discarded, and all other behaviour is identical.

## Test plan
- Reset, then push {addr 32'h00FF_0004, data 16'h4E71, write 0}; `frame_start` 3 cycles later → outputs = 00FF0004/4E71/0 on the following cycle, `fifo_level` 1→0.
- HOLD_FRAMES=3: push entries A, B; pulse `frame_start` 4 times → A shown after pulse 1, B after pulse 4, no change after pulses 2 and 3.
- DEPTH=4: push 6 entries with no `frame_start` → `fifo_level` = 4, `overflow_count` = 2 (macro on); pops return entries 1–4 in order.
- Full FIFO with `cap_valid` and a qualifying `frame_start` in the same cycle → entry popped, new capture accepted, `fifo_level` stays 4, `overflow_count` unchanged.
- `freeze` high across 5 `frame_start` pulses with 2 entries queued → outputs unchanged. Drop `freeze`, next `frame_start` → entry 1 shown.
- Assert `reset` asynchronously between pops with 3 entries queued → outputs = 0 and `fifo_level` = 0 immediately, without waiting for a `clk` edge.
